cmd_sequencer: RTL and testbench
================================

// Module: cmd_sequencer
// PURPOSE
//  Queues 16-bit Knight commands and issues them one at a time over the RemoteComm
//  send_cmd/cmd/cmd_sent/resp_rdy/resp handshake. Waits for each command's DONE (8'hA5)
//  before issuing the next, with per-phase timeout, bounded retry and sticky error report.
//  Sits between the tour planner / host-side stimulus and RemoteComm in the Knight system.
// PARAMETERS
//  DEPTH      8      command queue entries (power of 2, >=2)
//  TIMEOUT    10000  cycles allowed in WAIT_SENT and in WAIT_RESP, each
//  MAX_RETRY  2      re-issues of a failed command before ERROR
// PORTS
//  clk       in   1   system clock
//  rst       in   1   synchronous, active-high reset
//  push      in   1   enqueue push_cmd this cycle
//  push_cmd  in   16  command to enqueue
//  abort     in   1   flush queue, drop in-flight command, clear err
//  full      out  1   queue full (push ignored)
//  empty     out  1   queue empty
//  ovf       out  1   one-cycle pulse: push dropped because full
//  cmd       out  16  command to RemoteComm; stable from SEND until WAIT_RESP exits
//  send_cmd  out  1   one-cycle start pulse to RemoteComm
//  cmd_sent  in   1   RemoteComm: command transmitted (rising edge used)
//  resp_rdy  in   1   RemoteComm: response byte valid (rising edge used)
//  resp      in   8   response byte, sampled on resp_rdy rising edge
//  busy      out  1   state != IDLE
//  cmd_done  out  1   one-cycle pulse: head command acknowledged with 8'hA5
//  err       out  1   sticky: command failed MAX_RETRY+1 times
//  err_cmd   out  16  command that caused err
// BEHAVIOUR
//  Reset: queue empty; state IDLE; cmd=16'h0000; send_cmd, ovf, cmd_done, busy, err = 0;
//   err_cmd=16'h0000; retry cnt, timeout cnt, edge-detect flops = 0.
//  Queue: write on push && !full. full is evaluated before any same-cycle pop, so a push
//   while full is dropped and pulses ovf, even if a pop occurs in that cycle.
//  Edge detect: cmd_sent_rise = cmd_sent & ~cmd_sent_q; same for resp_rdy.
//  FSM (registered, Moore outputs):
//   IDLE      : !empty && !err -> SEND; latch head into cmd; retry cnt=0.
//   SEND      : send_cmd=1 for exactly this cycle; timeout cnt=0 -> WAIT_SENT.
//   WAIT_SENT : cmd_sent_rise -> WAIT_RESP (timeout cnt=0); cnt==TIMEOUT-1 -> FAIL.
//   WAIT_RESP : resp_rdy_rise && resp==8'hA5 -> pop head, cmd_done pulse next cycle, IDLE.
//               resp_rdy_rise && resp==8'h5A -> intermediate ack; reload timeout cnt, stay.
//               resp_rdy_rise && other resp  -> FAIL.  cnt==TIMEOUT-1 -> FAIL.
//   FAIL      : retry<MAX_RETRY -> retry++, SEND (same cmd);
//               else err=1, err_cmd=cmd, flush queue -> ERROR.
//   ERROR     : holds; pushes still accepted but not issued until abort.
//  abort (any state, highest priority after rst): next cycle state=IDLE, queue empty,
//   err=0, send_cmd=0, retry/timeout cnt=0; push on the abort cycle is discarded.
//  Latency: push into empty queue at cycle N (IDLE) -> send_cmd=1 at N+2.
//  Back-to-back: A5 accepted at cycle M with queue non-empty -> next send_cmd at M+2.
//  Timeout cnt width $clog2(TIMEOUT+1); saturates, never wraps. Rising edge already high
//   on entry to WAIT_* is not a new edge (edge flops track continuously in every state).
// STRUCTURE
//  Package knight_cmd_pkg: RESP_DONE=8'hA5, RESP_TRMT=8'h5A, typedef logic[15:0] cmd_t,
//   enum seq_state_t {IDLE,SEND,WAIT_SENT,WAIT_RESP,FAIL,ERROR}.
//  Sub-module cmd_fifo (DEPTH x cmd_t, sync, first-word-fall-through, flush input);
//   FSM, counters and edge detect stay in cmd_sequencer.
// TESTING
//  1 push 16'h2345 idle; cmd_sent 50 cyc after send_cmd, resp A5 -> send_cmd at N+2,
//    cmd=16'h2345, one cmd_done, busy falls, empty=1.
//  2 push 3 cmds back-to-back, each A5 -> three send_cmd pulses in order, next send at M+2.
//  3 resp 5A twice then A5 -> no retry, single send_cmd, one cmd_done.
//  4 never assert cmd_sent, MAX_RETRY=2 -> 3 send_cmd pulses TIMEOUT apart, then err=1,
//    err_cmd=head, queue flushed; abort -> err=0, IDLE next cycle.
//  5 fill DEPTH entries, push again -> ovf pulse, full=1, dropped cmd never issued.
//  6 abort during WAIT_RESP, late A5 arrives -> no cmd_done, state IDLE, queue empty.

Source files
------------

// File: rtl/knight_cmd_pkg.sv
// Shared types and constants for the Knight command sequencer.
package knight_cmd_pkg;

  localparam logic [7:0] RESP_DONE = 8'hA5;
  localparam logic [7:0] RESP_TRMT = 8'h5A;

  typedef logic [15:0] cmd_t;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_SENT,
    WAIT_RESP,
    FAIL,
    ERROR
  } seq_state_t;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous first-word-fall-through command queue with flush.
module cmd_fifo
  import knight_cmd_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic wr_en,
  input  cmd_t wr_data,
  input  logic rd_en,
  output cmd_t rd_data,
  output logic full,
  output logic empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  cmd_t            r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic            w_do_wr;
  logic            w_do_rd;

  // full/empty gate the raw requests, so a push while full is dropped
  // even if a pop happens in the same cycle
  assign w_do_wr = wr_en && !full;
  assign w_do_rd = rd_en && !empty;

  assign full    = (r_count == (AW+1)'(DEPTH));
  assign empty   = (r_count == '0);
  assign rd_data = r_mem[r_rd_ptr];

  // Pointer and occupancy bookkeeping; flush empties the queue
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array write port
  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/cmd_sequencer.sv
// Issues queued Knight commands one at a time over the RemoteComm handshake,
// waiting for DONE on each, with timeout, bounded retry and sticky error.
module cmd_sequencer
  import knight_cmd_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned TIMEOUT   = 10000,
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [15:0] push_cmd,
  input  logic        abort,
  output logic        full,
  output logic        empty,
  output logic        ovf,
  output logic [15:0] cmd,
  output logic        send_cmd,
  input  logic        cmd_sent,
  input  logic        resp_rdy,
  input  logic [7:0]  resp,
  output logic        busy,
  output logic        cmd_done,
  output logic        err,
  output logic [15:0] err_cmd
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT);
  localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

  seq_state_t     r_state;
  seq_state_t     w_next;
  logic           r_sent_q;
  logic           r_rdy_q;
  logic [TW-1:0]  r_to_cnt;
  logic [RW-1:0]  r_retry;
  cmd_t           r_cmd;
  cmd_t           r_err_cmd;
  logic           r_err;
  logic           r_ovf;
  logic           r_cmd_done;

  logic           w_sent_rise;
  logic           w_rdy_rise;
  logic           w_resp_done;
  logic           w_resp_trmt;
  logic           w_to_exp;
  logic           w_accept;
  logic           w_retry_ok;
  logic           w_give_up;
  logic           w_fifo_wr;
  logic           w_fifo_flush;
  logic           w_full;
  logic           w_empty;
  cmd_t           w_head;

  assign w_sent_rise  = cmd_sent & ~r_sent_q;
  assign w_rdy_rise   = resp_rdy & ~r_rdy_q;
  assign w_resp_done  = w_rdy_rise && (resp == RESP_DONE);
  assign w_resp_trmt  = w_rdy_rise && (resp == RESP_TRMT);
  assign w_to_exp     = (r_to_cnt == TO_LAST);
  assign w_accept     = (r_state == WAIT_RESP) && w_resp_done && !abort;
  assign w_retry_ok   = (r_retry < RETRY_LIM);
  assign w_give_up    = (r_state == FAIL) && !w_retry_ok && !abort;
  assign w_fifo_wr    = push && !abort;
  assign w_fifo_flush = abort || w_give_up;

  // The head entry stays queued until DONE, so retries re-read nothing
  cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (w_fifo_flush),
    .wr_en   (w_fifo_wr),
    .wr_data (push_cmd),
    .rd_en   (w_accept),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty)
  );

  assign full     = w_full;
  assign empty    = w_empty;
  assign ovf      = r_ovf;
  assign cmd      = r_cmd;
  assign cmd_done = r_cmd_done;
  assign err      = r_err;
  assign err_cmd  = r_err_cmd;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; abort overrides every state
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:      if (!w_empty && !r_err) w_next = SEND;
      SEND:      w_next = WAIT_SENT;
      WAIT_SENT: begin
        if (w_sent_rise)   w_next = WAIT_RESP;
        else if (w_to_exp) w_next = FAIL;
      end
      WAIT_RESP: begin
        if (w_rdy_rise) begin
          if (w_resp_done)       w_next = IDLE;
          else if (!w_resp_trmt) w_next = FAIL;
        end else if (w_to_exp) begin
          w_next = FAIL;
        end
      end
      FAIL:      w_next = w_retry_ok ? SEND : ERROR;
      ERROR:     w_next = ERROR;
      default:   w_next = IDLE;
    endcase
    if (abort) w_next = IDLE;
  end

  // Moore outputs decoded from the current state
  always_comb begin
    send_cmd = (r_state == SEND);
    busy     = (r_state != IDLE);
  end

  // Edge flops, counters, command latch, error report and pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sent_q   <= 1'b0;
      r_rdy_q    <= 1'b0;
      r_to_cnt   <= '0;
      r_retry    <= '0;
      r_cmd      <= '0;
      r_err      <= 1'b0;
      r_err_cmd  <= '0;
      r_ovf      <= 1'b0;
      r_cmd_done <= 1'b0;
    end else begin
      r_sent_q   <= cmd_sent;
      r_rdy_q    <= resp_rdy;
      r_ovf      <= push && w_full && !abort;
      r_cmd_done <= w_accept;
      if (abort) begin
        r_err    <= 1'b0;
        r_retry  <= '0;
        r_to_cnt <= '0;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (!w_empty && !r_err) begin
              r_cmd   <= w_head;
              r_retry <= '0;
            end
          end
          SEND: r_to_cnt <= '0;
          WAIT_SENT: begin
            if (w_sent_rise)             r_to_cnt <= '0;
            else if (r_to_cnt != TO_MAX) r_to_cnt <= r_to_cnt + 1'b1;
          end
          WAIT_RESP: begin
            if (w_resp_trmt)                          r_to_cnt <= '0;
            else if (!w_rdy_rise && r_to_cnt != TO_MAX) r_to_cnt <= r_to_cnt + 1'b1;
          end
          FAIL: begin
            if (w_retry_ok) begin
              r_retry <= r_retry + 1'b1;
            end else begin
              r_err     <= 1'b1;
              r_err_cmd <= r_cmd;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cmd_sequencer.sv
// Scoreboard bench for cmd_sequencer: stimulus queues expected issued and
// completed commands; a negedge monitor checks them as the DUT presents them.
module tb_cmd_sequencer;

  localparam int unsigned DEPTH     = 8;
  localparam int unsigned TIMEOUT   = 100;
  localparam int unsigned MAX_RETRY = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        push;
  logic [15:0] push_cmd;
  logic        abort;
  logic        full;
  logic        empty;
  logic        ovf;
  logic [15:0] cmd;
  logic        send_cmd;
  logic        cmd_sent;
  logic        resp_rdy;
  logic [7:0]  resp;
  logic        busy;
  logic        cmd_done;
  logic        err;
  logic [15:0] err_cmd;

  cmd_sequencer #(
    .DEPTH     (DEPTH),
    .TIMEOUT   (TIMEOUT),
    .MAX_RETRY (MAX_RETRY)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_cmd (push_cmd),
    .abort    (abort),
    .full     (full),
    .empty    (empty),
    .ovf      (ovf),
    .cmd      (cmd),
    .send_cmd (send_cmd),
    .cmd_sent (cmd_sent),
    .resp_rdy (resp_rdy),
    .resp     (resp),
    .busy     (busy),
    .cmd_done (cmd_done),
    .err      (err),
    .err_cmd  (err_cmd)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_send = 0;
  int n_done = 0;
  int last_send_cyc = 0;
  int last_done_cyc = 0;
  logic [15:0] exp_send_q[$];
  logic [15:0] exp_done_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: every send_cmd / cmd_done pulse is matched against the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (send_cmd) begin
        n_send++;
        last_send_cyc = cyc;
        if (exp_send_q.size() == 0) flag($sformatf("unexpected_send cmd=%0h", cmd));
        else chk("send_cmd_value", {16'h0, cmd}, {16'h0, exp_send_q.pop_front()});
      end
      if (cmd_done) begin
        n_done++;
        last_done_cyc = cyc;
        if (exp_done_q.size() == 0) flag($sformatf("unexpected_done cmd=%0h", cmd));
        else chk("cmd_done_value", {16'h0, cmd}, {16'h0, exp_done_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_push(input logic [15:0] c);
    push = 1'b1;
    push_cmd = c;
    step();
    push = 1'b0;
  endtask

  task automatic wait_sends(input int target, input int limit, input string name);
    int k = 0;
    while (n_send < target && k < limit) begin
      step();
      k++;
    end
    if (n_send < target) flag({name, "_send_timeout"});
  endtask

  task automatic pulse_sent();
    cmd_sent = 1'b1;
    step(2);
    cmd_sent = 1'b0;
  endtask

  task automatic send_resp(input logic [7:0] r, output int at);
    resp = r;
    resp_rdy = 1'b1;
    at = cyc;
    step();
    resp_rdy = 1'b0;
  endtask

  initial begin
    int pc, m, m_prev, ns, nd, s_prev;
    rst = 1'b1; push = 1'b0; push_cmd = '0; abort = 1'b0;
    cmd_sent = 1'b0; resp_rdy = 1'b0; resp = '0;
    step(3);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_ovf", ovf, 0);
    chk("rst_cmd", cmd, 0);
    chk("rst_send_cmd", send_cmd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_done", cmd_done, 0);
    chk("rst_err", err, 0);
    chk("rst_err_cmd", err_cmd, 0);
    rst = 1'b0;
    step(2);

    // 1: single command, cmd_sent 50 cycles after send_cmd, DONE
    ns = n_send; nd = n_done;
    exp_send_q.push_back(16'h2345);
    pc = cyc;
    do_push(16'h2345);
    wait_sends(ns + 1, 20, "t1");
    chk("t1_latency", last_send_cyc - pc, 2);
    step(49);
    chk("t1_busy_waiting", busy, 1);
    pulse_sent();
    step(3);
    exp_done_q.push_back(16'h2345);
    send_resp(8'hA5, m);
    step(2);
    chk("t1_done_count", n_done - nd, 1);
    chk("t1_done_cycle", last_done_cyc - m, 1);
    chk("t1_busy_low", busy, 0);
    chk("t1_empty", empty, 1);

    // 2: three back-to-back commands
    ns = n_send;
    for (int unsigned i = 0; i < 3; i++) begin
      exp_send_q.push_back(16'hA001 + 16'(i));
      do_push(16'hA001 + 16'(i));
    end
    m_prev = 0;
    for (int unsigned i = 0; i < 3; i++) begin
      wait_sends(ns + int'(i) + 1, 20, "t2");
      if (i > 0) chk("t2_b2b_latency", last_send_cyc - m_prev, 2);
      pulse_sent();
      step(2);
      exp_done_q.push_back(16'hA001 + 16'(i));
      send_resp(8'hA5, m);
      m_prev = m;
    end
    step(3);
    chk("t2_sends", n_send - ns, 3);
    chk("t2_empty", empty, 1);
    chk("t2_busy", busy, 0);

    // 3: two intermediate 5A acks, then DONE
    ns = n_send; nd = n_done;
    exp_send_q.push_back(16'h3C3C);
    do_push(16'h3C3C);
    wait_sends(ns + 1, 20, "t3");
    pulse_sent();
    step(2);
    send_resp(8'h5A, m);
    step(3);
    send_resp(8'h5A, m);
    step(3);
    exp_done_q.push_back(16'h3C3C);
    send_resp(8'hA5, m);
    step(3);
    chk("t3_sends", n_send - ns, 1);
    chk("t3_dones", n_done - nd, 1);
    chk("t3_busy", busy, 0);

    // 4: cmd_sent never arrives -> retries, sticky error, flush, abort
    ns = n_send;
    for (int unsigned i = 0; i <= MAX_RETRY; i++) exp_send_q.push_back(16'hBEEF);
    do_push(16'hBEEF);
    do_push(16'h1111);
    wait_sends(ns + 1, 20, "t4");
    s_prev = last_send_cyc;
    for (int unsigned i = 1; i <= MAX_RETRY; i++) begin
      wait_sends(ns + int'(i) + 1, TIMEOUT + 20, "t4_retry");
      chk("t4_retry_spacing", last_send_cyc - s_prev, TIMEOUT + 2);
      s_prev = last_send_cyc;
    end
    chk("t4_err_pending", err, 0);
    step(TIMEOUT + 5);
    chk("t4_err", err, 1);
    chk("t4_err_cmd", err_cmd, 16'hBEEF);
    chk("t4_flushed", empty, 1);
    chk("t4_busy_error", busy, 1);
    chk("t4_sends", n_send - ns, MAX_RETRY + 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t4_abort_err", err, 0);
    chk("t4_abort_idle", busy, 0);
    step(3);
    chk("t4_no_more_sends", n_send - ns, MAX_RETRY + 1);

    // 5: fill queue, overflow push is dropped and never issued
    ns = n_send;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      exp_send_q.push_back(16'h5000 + 16'(i));
      do_push(16'h5000 + 16'(i));
    end
    chk("t5_full", full, 1);
    do_push(16'hDEAD);
    chk("t5_ovf_pulse", ovf, 1);
    chk("t5_still_full", full, 1);
    step();
    chk("t5_ovf_low", ovf, 0);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      wait_sends(ns + int'(i) + 1, 20, "t5");
      pulse_sent();
      step(2);
      exp_done_q.push_back(16'h5000 + 16'(i));
      send_resp(8'hA5, m);
    end
    step(5);
    chk("t5_sends", n_send - ns, DEPTH);
    chk("t5_empty", empty, 1);
    chk("t5_busy", busy, 0);

    // 6: abort in WAIT_RESP, late DONE ignored
    ns = n_send; nd = n_done;
    exp_send_q.push_back(16'h6006);
    do_push(16'h6006);
    wait_sends(ns + 1, 20, "t6");
    pulse_sent();
    step(2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t6_abort_idle", busy, 0);
    chk("t6_abort_empty", empty, 1);
    step();
    send_resp(8'hA5, m);
    step(3);
    chk("t6_no_done", n_done - nd, 0);
    chk("t6_no_resend", n_send - ns, 1);
    chk("t6_idle", busy, 0);

    chk("sb_send_drained", exp_send_q.size(), 0);
    chk("sb_done_drained", exp_done_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
